// File: rtl/uart_rx_frame_ctrl.sv
// Oversampled UART receive sequencer: start qualification, data sampling, stop check, one-entry holding register.
// Optional parity stage and parity_err output are built when UART_RX_PARITY_EN is defined.
module uart_rx_frame_ctrl #(
    parameter int SAMPLE_RATE = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,parameter int PARITY_ODD = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_rate_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int TW = $clog2(SAMPLE_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_RATE - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(SAMPLE_RATE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [TW-1:0]          r_tick;
    logic [BW-1:0]          r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_load;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   w_rx_s;
    logic                   w_last_tick;
`ifdef UART_RX_PARITY_EN
    logic                   r_par_bit;
    logic                   r_parity_err;
    logic                   w_par_bad;

    assign w_par_bad  = ((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD);
    assign parity_err = r_parity_err;
`endif

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_last_tick = (r_tick == TICK_LAST);

    // Idle-high reset value keeps a fresh reset from looking like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (baud_rate_clk) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_rx_s) begin
                            r_state <= S_START;
                            r_tick  <= '0;
                        end
                    end
                    S_START: begin
                        if (r_tick == HALF_LAST) begin
                            if (!w_rx_s) begin
                                r_state <= S_DATA;
                                r_tick  <= '0;
                                r_bit   <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    // From here on every sample lands mid-bit, one full bit period apart.
                    S_DATA: begin
                        if (w_last_tick) begin
                            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_bit   <= r_bit + 1'b1;
                            r_tick  <= '0;
                            if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (w_last_tick) begin
                            r_par_bit <= w_rx_s;
                            r_tick    <= '0;
                            r_state   <= S_STOP;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_last_tick) begin
                            r_tick <= '0;
                            if (w_rx_s) begin
                                r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                                if (w_par_bad) begin
                                    r_parity_err <= 1'b1;
                                end else begin
                                    r_load <= 1'b1;
                                end
`else
                                r_load <= 1'b1;
`endif
                            end else begin
                                r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                r_parity_err <= w_par_bad;
`endif
                                r_state <= S_BREAK;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_BREAK: begin
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // A load in the same cycle as an accept replaces the word without an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_load) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule
